// File: rtl/pipe_mdu_ctrl_if.sv
// Handshake/result bundle between the ID stage and the multiply/divide sequencer.
// The master is the ID side; the slave is the sequencer.
interface pipe_mdu_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_hi;
  logic             rd_lo;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, rd_hi, rd_lo,
    input  stall, busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_hi, rd_lo,
    output stall, busy, done, hi, lo
  );
endinterface

// File: rtl/pipe_mdu_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO.
// Runs a WIDTH-step shift-add or restoring-divide loop on operand magnitudes, then sign-fixes.
module pipe_mdu_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = 6
) (
  input logic             clock,
  input logic             resetn,
  pipe_mdu_ctrl_if.slave  mdu
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;     // multiplier / dividend-then-quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;   // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             is_div_q, is_div_d, dz_q, dz_d, done_q, done_d;

  logic             busy, a_neg, b_neg, last_step;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, div_rem, div_diff;
  logic [2*WIDTH-1:0] prod, prod_neg;

  always_comb begin
    busy      = (state_q != StIdle);
    mdu.busy  = busy;
    mdu.stall = busy & (mdu.start | mdu.rd_hi | mdu.rd_lo);
    mdu.done  = done_q;
    mdu.hi    = hi_q;
    mdu.lo    = lo_q;

    a_neg     = ~mdu.op[0] & mdu.a[WIDTH-1];
    b_neg     = ~mdu.op[0] & mdu.b[WIDTH-1];
    mag_a     = a_neg ? (~mdu.a + 1'b1) : mdu.a;
    mag_b     = b_neg ? (~mdu.b + 1'b1) : mdu.b;
    mul_sum   = {1'b0, acc_q} + {1'b0, dvs_q};
    div_rem   = {acc_q, mq_q[WIDTH-1]};
    div_diff  = div_rem - {1'b0, dvs_q};
    prod      = {acc_q, mq_q};
    prod_neg  = ~prod + 1'b1;
    last_step = (count_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    dvs_d     = dvs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // stall is always 0 in IDLE, so start alone decides acceptance
        if (mdu.start) begin
          count_d   = '0;
          acc_d     = '0;
          mq_d      = mag_a;
          dvs_d     = mag_b;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          is_div_d  = mdu.op[1];
          dz_d      = 1'b0;
          if (mdu.op[1] && (mdu.b == '0)) begin
            dz_d    = 1'b1;
            acc_d   = mdu.a;
            mq_d    = '1;
            state_d = StFix;
          end else begin
            state_d = mdu.op[1] ? StDiv : StMul;
          end
        end
      end
      StMul: begin
        if (mq_q[0]) begin
          acc_d = mul_sum[WIDTH:1];
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end else begin
          acc_d = acc_q >> 1;
          mq_d  = {acc_q[0], mq_q[WIDTH-1:1]};
        end
        if (count_q != CW'(WIDTH)) count_d = count_q + 1'b1;
        if (last_step) state_d = StFix;
      end
      StDiv: begin
        if (!div_diff[WIDTH]) begin
          acc_d = div_diff[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_rem[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
        if (count_q != CW'(WIDTH)) count_d = count_q + 1'b1;
        if (last_step) state_d = StFix;
      end
      StFix: begin
        if (dz_q) begin
          hi_d = acc_q;
          lo_d = mq_q;
        end else if (is_div_q) begin
          lo_d = neg_res_q ? (~mq_q + 1'b1) : mq_q;
          hi_d = neg_rem_q ? (~acc_q + 1'b1) : acc_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      count_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      dvs_q     <= dvs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

endmodule
